color_xform_sched: RTL and testbench
====================================

# color_xform_sched

Scheduler and arbiter that shares one `color_transform` pipeline between two pixel sources, for example the left and right camera streams. Each cycle it grants at most one source and registers that pixel into the transform input. It tracks in-flight pixels with a tag pipeline and steers each transform result to the write request of its own destination FIFO. Per-destination credit counters ensure an issued pixel always has FIFO space on arrival, because the transform itself cannot stall.

## Interface
- `PIPE_LAT`, 3: transform latency in cycles from registered input to `xf_wrreq`.
- `FIFO_DEPTH`, 512: entries per destination FIFO; the credit counter's initial value.
- `CRED_W`, 10: credit counter width; must satisfy 2^CRED_W > FIFO_DEPTH.

Ports:
- `clk_25`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-low.
- `en`  in  1  run enable; sampled every cycle.
- `s0_valid`, `s1_valid`  in  1  source has a pixel.
- `s0_ready`, `s1_ready`  out  1  grant; the handshake completes when valid & ready.
- `s0_x`, `s1_x`, `s0_y`, `s1_y`  in  10  pixel coordinates.
- `s0_rgb`, `s1_rgb`  in  24  {red, green, blue}, 8 bits each.
- `xf_valid`  out  1  to transform `valid`.
- `xf_x`, `xf_y`  out  10  to transform `x_i`/`y_i`.
- `xf_red`, `xf_green`, `xf_blue`  out  8  to transform.
- `xf_wrreq`  in  1  transform output-valid.
- `d0_wrreq`, `d1_wrreq`  out  1  destination FIFO write enables; FIFO data is the shared transform output bus.
- `d0_rdreq`, `d1_rdreq`  in  1  consumer read of the destination FIFO; each pulse returns one credit.
- `busy`  out  1  state ≠ IDLE or any pixel in flight.
- `err`  out  1  sticky; `xf_wrreq` disagreed with the tag pipeline.

## Operation
- FSM:
  - IDLE → RUN when `en`=1.
  - RUN → DRAIN when `en`=0.
  - DRAIN → IDLE when the tag pipeline is empty and `xf_wrreq`=0.
  - DRAIN → RUN if `en` returns to 1.
- Eligibility: source k is eligible when state=RUN, `sk_valid`=1 and `credk` > 0.
- Round-robin:
  - Pointer `rr` holds the last granted source.
  - If both sources are eligible, grant the one ≠ `rr`; otherwise grant the single eligible source.
  - `rr` updates to the granted source on each grant.
  - `rr` resets to 1, so source 0 wins the first tie.
- `sk_ready` is combinational: (grant==k). Grants are only issued in RUN.
- Credits:
  - `credk` decrements on a grant to k and increments on `dk_rdreq`.
  - A grant and a read in the same cycle leave the count unchanged.
  - An increment at `FIFO_DEPTH` saturates.
- Tag pipeline: PIPE_LAT+1 entries of {valid, src}. Entry 0 is loaded alongside `xf_valid`; the last entry aligns with `xf_wrreq`.
- Steering: `dk_wrreq` = `xf_wrreq` & tag_last.valid & (tag_last.src==k). This is combinational, in the same cycle as `xf_wrreq`.
- Error: `err` sets when `xf_wrreq` ≠ tag_last.valid and stays set until reset.
- Reset mid-frame clears everything. In-flight transform results produced after reset are dropped: the tags are invalid and `err` latches, which is the expected result.

## Timing
- Handshake at cycle t → `xf_*` valid at t+1 → `xf_wrreq` at t+1+PIPE_LAT → `dk_wrreq` the same cycle.
- Issue rate: 1 pixel per cycle. Two sources that are both always valid alternate 0,1,0,1.
- Reset values:
  - `xf_valid`, `xf_*` data, `d*_wrreq`, `s*_ready`, `busy`, `err`: 0.
  - `cred0` = `cred1` = `FIFO_DEPTH`.
  - Tags: all invalid.
  - State: IDLE.
- Dropping `en` takes effect on the same cycle: no grant in the cycle `en`=0 is seen. In-flight pixels complete and are steered normally in DRAIN.
- When `credk`=0, source k is stalled. The first grant after a `dk_rdreq` can occur in the cycle after that read.

## Structure
- Shared package `color_pkg` holds:
  - the `rgb_t` struct and `pix_t` {x, y, rgb};
  - the sched state enum `sched_state_t` {IDLE, RUN, DRAIN};
  - `PIPE_LAT_DEFAULT`=3.
- One sub-module, `rr_arb2`: a 2-input round-robin arbiter (req[1:0], grant[1:0], pointer update). Credits, tags and the FSM stay in the top level.

## Test plan
- Reset, `en`=1, only s0 valid with (x=5, y=7, rgb=0x102030) → `s0_ready` at t, `xf_valid` at t+1 with the same fields, `d0_wrreq` at t+4, `d1_wrreq` stays 0.
- Both sources always valid, 8 cycles → grants 0,1,0,1,0,1,0,1, and each `dk_wrreq` pattern matches its source 4 cycles later.
- `FIFO_DEPTH`=4, no rdreq, s0 always valid → exactly 4 grants, then `s0_ready`=0. One `d0_rdreq` → one more grant the next cycle. Grant and rdreq in the same cycle leave credit at 0.
- `en` dropped after 3 issues → no further grants, `busy`=1 until the 3rd `d*_wrreq`, IDLE 1 cycle later, `busy`=0.
- Spurious `xf_wrreq` with the tag pipeline empty → `err`=1 and stays 1 through later traffic until reset.
- Reset asserted mid-stream with 2 in flight → all outputs 0 immediately, credits return to `FIFO_DEPTH`, no `dk_wrreq` for the dropped pixels.

Source files
------------

// File: rtl/color_pkg.sv
// Shared types for the colour-transform scheduler.
// Pixel bundles, scheduler state and in-flight tag layout.
package color_pkg;

    localparam int PIPE_LAT_DEFAULT = 3;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        rgb_t       rgb;
    } pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        logic valid;
        logic src;
    } tag_t;

endpackage

// File: rtl/color_xform_sched_rr_arb2.sv
// Two-way round-robin arbiter; rr remembers the last winner.
// On a tie the source that did not win last time is granted.
module rr_arb2 (
    input  logic       clk_25,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic rr;

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (req == 2'b11): grant = rr ? 2'b01 : 2'b10;
            (req == 2'b01): grant = 2'b01;
            (req == 2'b10): grant = 2'b10;
            default:        grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk_25 or negedge reset) begin
        if (!reset) begin
            rr <= 1'b1;
        end else if (|req) begin
            rr <= grant[1];
        end
    end

endmodule

// File: rtl/color_xform_sched.sv
// Shares one non-stallable colour transform between two pixel sources,
// steering each result to its own FIFO under credit flow control.
module color_xform_sched
    import color_pkg::*;
#(
    parameter int PIPE_LAT   = PIPE_LAT_DEFAULT,
    parameter int FIFO_DEPTH = 512,
    parameter int CRED_W     = 10
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic        en,
    input  logic        s0_valid,
    input  logic        s1_valid,
    output logic        s0_ready,
    output logic        s1_ready,
    input  logic [9:0]  s0_x,
    input  logic [9:0]  s1_x,
    input  logic [9:0]  s0_y,
    input  logic [9:0]  s1_y,
    input  logic [23:0] s0_rgb,
    input  logic [23:0] s1_rgb,
    output logic        xf_valid,
    output logic [9:0]  xf_x,
    output logic [9:0]  xf_y,
    output logic [7:0]  xf_red,
    output logic [7:0]  xf_green,
    output logic [7:0]  xf_blue,
    input  logic        xf_wrreq,
    output logic        d0_wrreq,
    output logic        d1_wrreq,
    input  logic        d0_rdreq,
    input  logic        d1_rdreq,
    output logic        busy,
    output logic        err
);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

    sched_state_t      state;
    logic [CRED_W-1:0] cred [2];
    tag_t              tags [PIPE_LAT+1];
    tag_t              tag_last;
    pix_t              pix0, pix1, xf_pix;
    logic [1:0]        req, grant, rdreq;
    logic              run, tags_empty;

    assign run    = (state == RUN) && en;
    assign req[0] = run && s0_valid && (cred[0] != '0);
    assign req[1] = run && s1_valid && (cred[1] != '0);
    assign rdreq  = {d1_rdreq, d0_rdreq};
    assign pix0   = {s0_x, s0_y, s0_rgb};
    assign pix1   = {s1_x, s1_y, s1_rgb};

    rr_arb2 u_arb (
        .clk_25 (clk_25),
        .reset  (reset),
        .req    (req),
        .grant  (grant)
    );

    assign s0_ready = grant[0];
    assign s1_ready = grant[1];

    assign xf_x     = xf_pix.x;
    assign xf_y     = xf_pix.y;
    assign xf_red   = xf_pix.rgb.red;
    assign xf_green = xf_pix.rgb.green;
    assign xf_blue  = xf_pix.rgb.blue;

    // Results are steered purely by the tag that travelled with the pixel.
    assign tag_last = tags[PIPE_LAT];
    assign d0_wrreq = xf_wrreq & tag_last.valid & ~tag_last.src;
    assign d1_wrreq = xf_wrreq & tag_last.valid &  tag_last.src;

    always_comb begin
        tags_empty = 1'b1;
        for (int i = 0; i <= PIPE_LAT; i++) begin
            if (tags[i].valid) tags_empty = 1'b0;
        end
    end

    assign busy = (state != IDLE) || !tags_empty;

    always_ff @(posedge clk_25 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (!en) state <= DRAIN;
                DRAIN: begin
                    if (en) state <= RUN;
                    else if (tags_empty && !xf_wrreq) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_25 or negedge reset) begin
        if (!reset) begin
            xf_valid <= 1'b0;
            xf_pix   <= '0;
        end else begin
            xf_valid <= |grant;
            if (|grant) xf_pix <= grant[1] ? pix1 : pix0;
        end
    end

    always_ff @(posedge clk_25 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) cred[k] <= CRED_MAX;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (grant[k] && !rdreq[k]) begin
                    cred[k] <= cred[k] - 1'b1;
                end else if (!grant[k] && rdreq[k] && cred[k] != CRED_MAX) begin
                    cred[k] <= cred[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= PIPE_LAT; i++) tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: |grant, src: grant[1]};
            for (int i = 1; i <= PIPE_LAT; i++) tags[i] <= tags[i-1];
        end
    end

    always_ff @(posedge clk_25 or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (xf_wrreq != tag_last.valid) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_color_xform_sched.sv
// Bench for color_xform_sched: directed sequences, a credit table and
// random traffic checked against a queue-based reference model.
module tb_color_xform_sched;
    import color_pkg::*;

    localparam int PL    = 3;
    localparam int DEPTH = 4;

    logic        clk_25 = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic        s0_ready, s1_ready;
    logic [9:0]  s0_x = '0, s1_x = '0, s0_y = '0, s1_y = '0;
    logic [23:0] s0_rgb = '0, s1_rgb = '0;
    logic        xf_valid;
    logic [9:0]  xf_x, xf_y;
    logic [7:0]  xf_red, xf_green, xf_blue;
    logic        xf_wrreq;
    logic        d0_wrreq, d1_wrreq;
    logic        d0_rdreq = 1'b0, d1_rdreq = 1'b0;
    logic        busy, err;
    logic        inj = 1'b0;
    logic [PL-1:0] xpipe = '0;

    always #5 clk_25 = ~clk_25;

    // Stand-in transform: fixed latency, not cleared by the scheduler reset.
    always @(posedge clk_25) xpipe <= {xpipe[PL-2:0], xf_valid};
    assign xf_wrreq = xpipe[PL-1] | inj;

    color_xform_sched #(
        .PIPE_LAT   (PL),
        .FIFO_DEPTH (DEPTH),
        .CRED_W     (3)
    ) dut (
        .clk_25   (clk_25),
        .reset    (reset),
        .en       (en),
        .s0_valid (s0_valid),
        .s1_valid (s1_valid),
        .s0_ready (s0_ready),
        .s1_ready (s1_ready),
        .s0_x     (s0_x),
        .s1_x     (s1_x),
        .s0_y     (s0_y),
        .s1_y     (s1_y),
        .s0_rgb   (s0_rgb),
        .s1_rgb   (s1_rgb),
        .xf_valid (xf_valid),
        .xf_x     (xf_x),
        .xf_y     (xf_y),
        .xf_red   (xf_red),
        .xf_green (xf_green),
        .xf_blue  (xf_blue),
        .xf_wrreq (xf_wrreq),
        .d0_wrreq (d0_wrreq),
        .d1_wrreq (d1_wrreq),
        .d0_rdreq (d0_rdreq),
        .d1_rdreq (d1_rdreq),
        .busy     (busy),
        .err      (err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN} mst_t;
    typedef struct {
        int due;
        int src;
    } fl_t;

    mst_t m_st;
    int   m_rr;
    int   cr [2];
    bit   m_err;
    bit   m_xv;
    pix_t m_xp;
    fl_t  q [$];

    typedef struct packed {
        bit en, v0, v1, rd0, rd1, r0, r1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic pix_t rp();
        pix_t p;
        p = {10'($urandom), 10'($urandom), 24'($urandom)};
        return p;
    endfunction

    task automatic model_reset();
        m_st  = M_IDLE;
        m_rr  = 1;
        cr[0] = DEPTH;
        cr[1] = DEPTH;
        m_err = 1'b0;
        m_xv  = 1'b0;
        m_xp  = '0;
        q.delete();
    endtask

    task automatic model_step();
        bit run, e0, e1, tv, empty;
        int g, ts;
        run = (m_st == M_RUN) && en;
        e0  = run && s0_valid && (cr[0] > 0);
        e1  = run && s1_valid && (cr[1] > 0);
        if (e0 && e1) g = (m_rr == 1) ? 0 : 1;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        else          g = -1;
        chk("s0_ready", 32'(s0_ready), 32'(g == 0));
        chk("s1_ready", 32'(s1_ready), 32'(g == 1));
        chk("xf_valid", 32'(xf_valid), 32'(m_xv));
        if (m_xv) begin
            chk("xf_xy", 32'({xf_x, xf_y}), 32'({m_xp.x, m_xp.y}));
            chk("xf_rgb", 32'({xf_red, xf_green, xf_blue}), 32'(m_xp.rgb));
        end
        empty = (q.size() == 0);
        chk("busy", 32'(busy), 32'((m_st != M_IDLE) || !empty));
        tv = 1'b0;
        ts = 0;
        if (!empty && q[0].due == cyc) begin
            tv = 1'b1;
            ts = q[0].src;
            void'(q.pop_front());
        end
        chk("d0_wrreq", 32'(d0_wrreq), 32'(xf_wrreq && tv && ts == 0));
        chk("d1_wrreq", 32'(d1_wrreq), 32'(xf_wrreq && tv && ts == 1));
        chk("err", 32'(err), 32'(m_err));
        if (xf_wrreq != tv) m_err = 1'b1;
        case (m_st)
            M_IDLE:  if (en) m_st = M_RUN;
            M_RUN:   if (!en) m_st = M_DRAIN;
            default: begin
                if (en) m_st = M_RUN;
                else if (empty && !xf_wrreq) m_st = M_IDLE;
            end
        endcase
        if (g >= 0) cr[g]--;
        if (d0_rdreq && cr[0] < DEPTH) cr[0]++;
        if (d1_rdreq && cr[1] < DEPTH) cr[1]++;
        m_xv = (g >= 0);
        if (g >= 0) begin
            m_rr = g;
            q.push_back('{cyc + 1 + PL, g});
            m_xp = (g == 1) ? pix_t'({s1_x, s1_y, s1_rgb})
                            : pix_t'({s0_x, s0_y, s0_rgb});
        end
        cyc++;
    endtask

    task automatic step(input bit e, input bit v0, input bit v1,
                        input pix_t p0, input pix_t p1,
                        input bit r0, input bit r1, input bit ij);
        @(negedge clk_25);
        en       = e;
        s0_valid = v0;
        s1_valid = v1;
        {s0_x, s0_y, s0_rgb} = p0;
        {s1_x, s1_y, s1_rgb} = p1;
        d0_rdreq = r0;
        d1_rdreq = r1;
        inj      = ij;
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk_25);
        reset    = 1'b0;
        en       = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        d0_rdreq = 1'b0;
        d1_rdreq = 1'b0;
        inj      = 1'b0;
        #1;
        chk("rst_ready", 32'({s1_ready, s0_ready}), 32'd0);
        chk("rst_xf_valid", 32'(xf_valid), 32'd0);
        chk("rst_xf_xy", 32'({xf_x, xf_y}), 32'd0);
        chk("rst_xf_rgb", 32'({xf_red, xf_green, xf_blue}), 32'd0);
        chk("rst_dwr", 32'({d1_wrreq, d0_wrreq}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        model_reset();
        @(posedge clk_25);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        pix_t z, pa;
        vec_t tbl [13];
        int   seen, n;
        bit   e;
        z  = '0;
        pa = {10'd5, 10'd7, 24'h102030};

        // Single pixel end to end.
        do_reset();
        step(1, 1, 0, pa, z, 0, 0, 0);
        chk("A_idle_noready", 32'(s0_ready), 32'd0);
        step(1, 1, 0, pa, z, 0, 0, 0);
        chk("A_ready", 32'(s0_ready), 32'd1);
        step(1, 0, 0, z, z, 0, 0, 0);
        chk("A_xf_valid", 32'(xf_valid), 32'd1);
        chk("A_xf_xy", 32'({xf_x, xf_y}), 32'({10'd5, 10'd7}));
        chk("A_xf_rgb", 32'({xf_red, xf_green, xf_blue}), 32'h102030);
        step(1, 0, 0, z, z, 0, 0, 0);
        chk("A_d0_early", 32'(d0_wrreq), 32'd0);
        step(1, 0, 0, z, z, 0, 0, 0);
        chk("A_d0_early", 32'(d0_wrreq), 32'd0);
        step(1, 0, 0, z, z, 0, 0, 0);
        chk("A_d0", 32'(d0_wrreq), 32'd1);
        chk("A_d1", 32'(d1_wrreq), 32'd0);

        // Both sources always valid: strict alternation, steered 4 later.
        do_reset();
        step(1, 1, 1, rp(), rp(), 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, i < 8, i < 8, rp(), rp(), 1, 1, 0);
            if (i < 8)
                chk("B_grant", 32'({s1_ready, s0_ready}),
                    (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i >= 4)
                chk("B_dest", 32'({d1_wrreq, d0_wrreq}),
                    ((i - 4) % 2 == 1) ? 32'd2 : 32'd1);
        end

        // Credit exhaustion and return, table driven.
        tbl[0]  = 7'b110_00_00;
        tbl[1]  = 7'b110_00_10;
        tbl[2]  = 7'b110_00_10;
        tbl[3]  = 7'b110_00_10;
        tbl[4]  = 7'b110_00_10;
        tbl[5]  = 7'b110_00_00;
        tbl[6]  = 7'b110_10_00;
        tbl[7]  = 7'b110_00_10;
        tbl[8]  = 7'b110_10_00;
        tbl[9]  = 7'b110_10_10;
        tbl[10] = 7'b110_00_10;
        tbl[11] = 7'b110_00_00;
        tbl[12] = 7'b111_00_01;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].v0, tbl[i].v1, rp(), rp(),
                 tbl[i].rd0, tbl[i].rd1, 0);
            chk($sformatf("C_row%0d_r0", i), 32'(s0_ready), 32'(tbl[i].r0));
            chk($sformatf("C_row%0d_r1", i), 32'(s1_ready), 32'(tbl[i].r1));
        end
        repeat (8) step(0, 0, 0, z, z, 1, 1, 0);

        // Dropping en after three issues, then drain to idle.
        do_reset();
        step(1, 1, 0, rp(), z, 0, 0, 0);
        repeat (3) begin
            step(1, 1, 0, rp(), z, 0, 0, 0);
            chk("D_issue", 32'(s0_ready), 32'd1);
        end
        step(0, 1, 0, rp(), z, 0, 0, 0);
        chk("D_en_low_nogrant", 32'(s0_ready), 32'd0);
        seen = 0;
        for (int i = 0; i < 12 && seen < 3; i++) begin
            step(0, 1, 0, rp(), z, 0, 0, 0);
            chk("D_busy", 32'(busy), 32'd1);
            chk("D_nogrant", 32'(s0_ready), 32'd0);
            if (d0_wrreq) seen++;
        end
        chk("D_three_writes", 32'(seen), 32'd3);
        step(0, 0, 0, z, z, 0, 0, 0);
        step(0, 0, 0, z, z, 0, 0, 0);
        chk("D_idle_busy", 32'(busy), 32'd0);

        // Spurious transform output with nothing in flight.
        do_reset();
        step(0, 0, 0, z, z, 0, 0, 1);
        chk("E_err_before", 32'(err), 32'd0);
        step(0, 0, 0, z, z, 0, 0, 0);
        chk("E_err_set", 32'(err), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, rp(), rp(), 1, 1, 0);
            chk("E_err_sticky", 32'(err), 32'd1);
        end
        repeat (6) step(0, 0, 0, z, z, 1, 1, 0);

        // Reset with pixels in flight: results dropped, credits restored.
        do_reset();
        step(1, 1, 0, rp(), z, 0, 0, 0);
        step(1, 1, 0, rp(), z, 0, 0, 0);
        step(1, 1, 0, rp(), z, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, z, z, 0, 0, 0);
            chk("F_drop_d0", 32'(d0_wrreq), 32'd0);
        end
        chk("F_err_latched", 32'(err), 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, rp(), z, 0, 0, 0);
            if (s0_ready) n++;
        end
        chk("F_credits", 32'(n), 32'(DEPTH));

        // Random traffic against the reference model.
        do_reset();
        e = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) e = !e;
            step(e, $urandom_range(3) != 0, $urandom_range(2) != 0,
                 rp(), rp(), $urandom_range(2) == 0,
                 $urandom_range(1) == 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
